// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator slice: the car-controller state
// encoding and the default floor width / floor count used by the request
// FIFO, the car controller and the request capture logic.
// ---------------------------------------------------------------------------
package elevator_pkg;

   // Default floor geometry shared by every block on the request path.
   localparam int FLOOR_WIDTH = 4;
   localparam int NUM_FLOORS  = 16;

   // Car controller state encoding.
   localparam int              STATE_WIDTH = 3;
   localparam logic [2:0]      ST_IDLE     = 3'd0;
   localparam logic [2:0]      ST_POP      = 3'd1;
   localparam logic [2:0]      ST_LOAD     = 3'd2;
   localparam logic [2:0]      ST_MOVE     = 3'd3;
   localparam logic [2:0]      ST_DOOR     = 3'd4;

   typedef enum logic [STATE_WIDTH-1:0] {
      S_IDLE = ST_IDLE,
      S_POP  = ST_POP,
      S_LOAD = ST_LOAD,
      S_MOVE = ST_MOVE,
      S_DOOR = ST_DOOR
   } car_state_t;

endpackage

// File: rtl/elevator_car_ctrl_tick_timer.sv
// ---------------------------------------------------------------------------
// car_tick_timer
// Small cycle counter shared by the MOVE (per-floor travel) and DOOR
// (door-open hold) phases of the car controller.
//
// Ports:
//   i_clock   in   system clock, rising edge
//   i_rst_n   in   asynchronous active-low reset
//   clear     in   force count to 0 (has priority over enable)
//   enable    in   count this cycle
//   terminal  in   last count value of the current interval
//   done      out  high on an enabled cycle where count == terminal; the
//                  count wraps to 0 on that same edge so the next interval
//                  starts cleanly without an explicit clear
// ---------------------------------------------------------------------------
module car_tick_timer #(
   parameter int pTIMER_WIDTH = 8
) (
   input  logic                    i_clock,
   input  logic                    i_rst_n,
   input  logic                    clear,
   input  logic                    enable,
   input  logic [pTIMER_WIDTH-1:0] terminal,
   output logic                    done
);

   logic [pTIMER_WIDTH-1:0] count;

   assign done = enable && !clear && (count == terminal);

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= done ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/elevator_car_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_car_ctrl
// Consumer side of the floor-request FIFO. Pops one request at a time,
// range-checks it, steps the car one floor every pTICKS_PER_FLOOR cycles
// toward the target, then holds the door open for pDOOR_TICKS cycles
// before returning to IDLE for the next request.
//
// Ports:
//   i_clock          in   system clock, rising edge
//   i_rst_n          in   asynchronous active-low reset
//   i_fifo_empty     in   FIFO empty flag (looked at only in IDLE)
//   i_fifo_rd_data   in   FIFO read data, valid the cycle after o_fifo_rd_en
//   o_fifo_rd_en     out  one-cycle FIFO pop strobe
//   o_current_floor  out  registered car position
//   o_target_floor   out  registered destination of the active request
//   o_moving_up      out  MOVE and target > current
//   o_moving_down    out  MOVE and target < current
//   o_door_open      out  DOOR state
//   o_busy           out  any state other than IDLE
//   o_req_error      out  one-cycle pulse after popping an out-of-range floor
// ---------------------------------------------------------------------------
module elevator_car_ctrl
   import elevator_pkg::*;
#(
   parameter int pFLOOR_WIDTH     = FLOOR_WIDTH,
   parameter int pNUM_FLOORS      = NUM_FLOORS,
   parameter int pTICKS_PER_FLOOR = 8,
   parameter int pDOOR_TICKS      = 12,
   parameter int pTIMER_WIDTH     = 8
) (
   input  logic                    i_clock,
   input  logic                    i_rst_n,
   input  logic                    i_fifo_empty,
   input  logic [pFLOOR_WIDTH-1:0] i_fifo_rd_data,
   output logic                    o_fifo_rd_en,
   output logic [pFLOOR_WIDTH-1:0] o_current_floor,
   output logic [pFLOOR_WIDTH-1:0] o_target_floor,
   output logic                    o_moving_up,
   output logic                    o_moving_down,
   output logic                    o_door_open,
   output logic                    o_busy,
   output logic                    o_req_error
);

   localparam logic [pTIMER_WIDTH-1:0] MOVE_LAST = pTIMER_WIDTH'(pTICKS_PER_FLOOR - 1);
   localparam logic [pTIMER_WIDTH-1:0] DOOR_LAST = pTIMER_WIDTH'(pDOOR_TICKS - 1);
   localparam logic [pFLOOR_WIDTH-1:0] ONE_FLOOR = pFLOOR_WIDTH'(1);
   localparam logic [31:0]             FLOOR_LIMIT = 32'(pNUM_FLOORS);

   car_state_t                state;
   car_state_t                state_next;
   logic [pFLOOR_WIDTH-1:0]   current;
   logic [pFLOOR_WIDTH-1:0]   current_next;
   logic [pFLOOR_WIDTH-1:0]   target;
   logic [pFLOOR_WIDTH-1:0]   target_next;
   logic                      req_error_next;

   logic                      timer_clear;
   logic                      timer_enable;
   logic [pTIMER_WIDTH-1:0]   timer_terminal;
   logic                      tick_done;

   logic [31:0]               rd_data_ext;
   logic                      req_in_range;
   logic [pFLOOR_WIDTH-1:0]   step_floor;

   // Zero-extend before comparing so pNUM_FLOORS == 2**pFLOOR_WIDTH still
   // works (every encodable value is then valid).
   assign rd_data_ext  = 32'(i_fifo_rd_data);
   assign req_in_range = (rd_data_ext < FLOOR_LIMIT);

   // Target was range-checked before MOVE, so the step can never wrap.
   assign step_floor = (target > current) ? (current + ONE_FLOOR)
                                          : (current - ONE_FLOOR);

   // The timer only runs in MOVE and DOOR; every other state holds it at 0,
   // which gives MOVE/DOOR entered from LOAD a fresh count. MOVE -> DOOR
   // relies on the timer's own wrap at the last floor step.
   assign timer_enable   = (state == S_MOVE) || (state == S_DOOR);
   assign timer_clear    = !timer_enable;
   assign timer_terminal = (state == S_MOVE) ? MOVE_LAST : DOOR_LAST;

   car_tick_timer #(
      .pTIMER_WIDTH (pTIMER_WIDTH)
   ) u_tick_timer (
      .i_clock  (i_clock),
      .i_rst_n  (i_rst_n),
      .clear    (timer_clear),
      .enable   (timer_enable),
      .terminal (timer_terminal),
      .done     (tick_done)
   );

   always_comb begin
      state_next     = state;
      current_next   = current;
      target_next    = target;
      req_error_next = 1'b0;
      case (state)
         S_IDLE: begin
            if (!i_fifo_empty) begin
               state_next = S_POP;
            end
         end
         S_POP: begin
            state_next = S_LOAD;
         end
         S_LOAD: begin
            if (!req_in_range) begin
               req_error_next = 1'b1;
               state_next     = S_IDLE;
            end else begin
               target_next = i_fifo_rd_data;
               state_next  = (i_fifo_rd_data == current) ? S_DOOR : S_MOVE;
            end
         end
         S_MOVE: begin
            if (tick_done) begin
               current_next = step_floor;
               if (step_floor == target) begin
                  state_next = S_DOOR;
               end
            end
         end
         S_DOOR: begin
            if (tick_done) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Outputs are registered decodes of the next state so they line up
   // exactly with the state they describe.
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= S_IDLE;
         current       <= '0;
         target        <= '0;
         o_fifo_rd_en  <= 1'b0;
         o_moving_up   <= 1'b0;
         o_moving_down <= 1'b0;
         o_door_open   <= 1'b0;
         o_busy        <= 1'b0;
         o_req_error   <= 1'b0;
      end else begin
         state         <= state_next;
         current       <= current_next;
         target        <= target_next;
         o_fifo_rd_en  <= (state_next == S_POP);
         o_moving_up   <= (state_next == S_MOVE) && (target_next > current_next);
         o_moving_down <= (state_next == S_MOVE) && (target_next < current_next);
         o_door_open   <= (state_next == S_DOOR);
         o_busy        <= (state_next != S_IDLE);
         o_req_error   <= req_error_next;
      end
   end

   assign o_current_floor = current;
   assign o_target_floor  = target;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_car_ctrl
// Self-checking bench for elevator_car_ctrl. A queue stands in for the
// request FIFO; each request is scored against a trip model that predicts
// the whole trip (pop count, cycles moving up/down, door time, error pulse,
// final floor/target, floor position over time) from the start floor and
// the requested floor.
// ---------------------------------------------------------------------------
module tb_elevator_car_ctrl;

   localparam int FW = 4;
   localparam int NF = 10;
   localparam int TPF = 8;
   localparam int DT = 12;

   logic          clk;
   logic          rst_n;
   logic          fifo_empty;
   logic [FW-1:0] fifo_rd_data;
   logic          fifo_rd_en;
   logic [FW-1:0] current_floor;
   logic [FW-1:0] target_floor;
   logic          moving_up;
   logic          moving_down;
   logic          door_open;
   logic          busy;
   logic          req_error;

   int checks = 0;
   int errors = 0;
   int q[$];
   int model_floor = 0;
   int model_target = 0;
   int txn_id = 0;

   elevator_car_ctrl #(
      .pFLOOR_WIDTH     (FW),
      .pNUM_FLOORS      (NF),
      .pTICKS_PER_FLOOR (TPF),
      .pDOOR_TICKS      (DT),
      .pTIMER_WIDTH     (8)
   ) dut (
      .i_clock         (clk),
      .i_rst_n         (rst_n),
      .i_fifo_empty    (fifo_empty),
      .i_fifo_rd_data  (fifo_rd_data),
      .o_fifo_rd_en    (fifo_rd_en),
      .o_current_floor (current_floor),
      .o_target_floor  (target_floor),
      .o_moving_up     (moving_up),
      .o_moving_down   (moving_down),
      .o_door_open     (door_open),
      .o_busy          (busy),
      .o_req_error     (req_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_req(input int v);
      q.push_back(v);
      fifo_empty = 1'b0;
   endtask

   // Advance one cycle, sampling on the falling edge; acts as the FIFO read
   // port by presenting popped data well before the LOAD edge.
   task automatic step_cycle();
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
         if (q.size() == 0) begin
            chk("pop_while_empty", 1, 0);
         end else begin
            fifo_rd_data = FW'(q.pop_front());
         end
         fifo_empty = (q.size() == 0);
      end
   endtask

   // Serve one queued request, starting the cycle after the DUT has seen
   // a non-empty FIFO in IDLE.
   task automatic serve(input int req);
      int c;
      bit valid;
      int exp_up, exp_down, exp_door, exp_err;
      int n_rd, n_up, n_down, n_door, n_err, err_at3, active_at3;
      int path_bad, both_bad, mv, exp_fl;
      bit finished;
      c = model_floor;
      valid = (req < NF);
      exp_up   = (valid && req > c) ? TPF * (req - c) : 0;
      exp_down = (valid && req < c) ? TPF * (c - req) : 0;
      exp_door = valid ? DT : 0;
      exp_err  = valid ? 0 : 1;
      n_rd = 0; n_up = 0; n_down = 0; n_door = 0; n_err = 0;
      err_at3 = 0; active_at3 = 0; path_bad = 0; both_bad = 0; mv = 0;
      finished = 0;
      for (int k = 1; k <= 3000; k++) begin
         step_cycle();
         if (fifo_rd_en) n_rd++;
         if (moving_up) n_up++;
         if (moving_down) n_down++;
         if (door_open) n_door++;
         if (req_error) n_err++;
         if (moving_up && moving_down) both_bad++;
         if (k == 3) begin
            err_at3 = req_error;
            active_at3 = (moving_up || moving_down || door_open) ? 1 : 0;
         end
         if (moving_up || moving_down) begin
            exp_fl = (req > c) ? c + mv / TPF : c - mv / TPF;
            if (int'(current_floor) != exp_fl) path_bad++;
            mv++;
         end
         if (door_open && int'(current_floor) != req) path_bad++;
         if (k > 1 && !busy) begin
            finished = 1;
            break;
         end
      end
      if (!finished) chk("trip_timeout", 0, 1);
      if (valid) begin
         model_floor = req;
         model_target = req;
      end
      chk("rd_pulses", n_rd, 1);
      chk("up_cycles", n_up, exp_up);
      chk("down_cycles", n_down, exp_down);
      chk("door_cycles", n_door, exp_door);
      chk("err_pulses", n_err, exp_err);
      chk("err_timing", err_at3, exp_err);
      chk("start_latency", active_at3, valid ? 1 : 0);
      chk("floor_path", path_bad, 0);
      chk("up_down_excl", both_bad, 0);
      chk("final_floor", int'(current_floor), model_floor);
      chk("final_target", int'(target_floor), model_target);
      $display("TXN %0d req=%0d from=%0d up=%0d down=%0d door=%0d err=%0d floor=%0d",
               txn_id, req, c, n_up, n_down, n_door, n_err, current_floor);
      txn_id++;
   endtask

   initial begin
      int bad_rd, bad_busy, bad_floor, r, r2;
      rst_n = 1'b0;
      fifo_empty = 1'b1;
      fifo_rd_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_floor", int'(current_floor), 0);
      chk("rst_target", int'(target_floor), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rd_en", int'(fifo_rd_en), 0);
      chk("rst_door", int'(door_open), 0);
      rst_n = 1'b1;

      // Empty FIFO: nothing may happen.
      bad_rd = 0; bad_busy = 0; bad_floor = 0;
      for (int i = 0; i < 50; i++) begin
         step_cycle();
         if (fifo_rd_en) bad_rd++;
         if (busy) bad_busy++;
         if (current_floor != 0) bad_floor++;
      end
      chk("idle_rd_en", bad_rd, 0);
      chk("idle_busy", bad_busy, 0);
      chk("idle_floor", bad_floor, 0);

      // Directed trips: up 0->3, down 5->2, same floor 4->4, out of range.
      push_req(3);  serve(3);
      push_req(5);  serve(5);
      push_req(2);  serve(2);
      push_req(4);  serve(4);
      push_req(4);  serve(4);
      push_req(12); serve(12);
      push_req(7);  serve(7);

      // Reset in the middle of a 2 -> 6 trip with another request queued.
      push_req(2);  serve(2);
      push_req(6);
      push_req(3);
      repeat (30) step_cycle();
      chk("pre_rst_moving_up", int'(moving_up), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_floor", int'(current_floor), 0);
      chk("arst_target", int'(target_floor), 0);
      chk("arst_moving", int'(moving_up) + int'(moving_down), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_door", int'(door_open), 0);
      model_floor = 0;
      model_target = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      serve(3);

      // Random requests, including out-of-range ones, back-to-back pairs
      // and idle gaps.
      for (int t = 0; t < 25; t++) begin
         r = $urandom_range(0, 15);
         if ($urandom_range(0, 2) == 0) begin
            r2 = $urandom_range(0, 15);
            push_req(r);
            push_req(r2);
            serve(r);
            serve(r2);
         end else begin
            push_req(r);
            serve(r);
         end
         repeat ($urandom_range(0, 3)) step_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
